vga_clut_mport: RTL and testbench
=================================

Name: vga_clut_mport

Overview:
- N-port cycle-shared controller for the colour lookup table (CLUT). It is the generalised successor of the two-port CLUT sharing used beside the VGA controller.
- Arbitrates up to NPORTS Wishbone slave ports onto one external synchronous-read, byte-writable dual-port RAM.
- Typical use: port 0 is the VGA pixel-fetch master; the other ports are host/DMA register access.
- Supports round-robin or port-0-priority arbitration, byte-lane writes, and error termination.

Parameters:
- NPORTS, 2: number of slave ports (2..8).
- DWIDTH, 24: CLUT entry width; must be a multiple of 8.
- AWIDTH, 9: CLUT address width; depth is 2**AWIDTH.
- PRIO0, 0: 0 = round-robin among all ports; 1 = port 0 wins whenever it requests, and the remaining ports round-robin.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_adr_i  in  NPORTS*AWIDTH  per-port entry address; port p is bits [p*AWIDTH +: AWIDTH]
- wb_dat_i  in  NPORTS*DWIDTH  per-port write data
- wb_dat_o  out  NPORTS*DWIDTH  per-port read data
- wb_sel_i  in  NPORTS*(DWIDTH/8)  per-port byte selects
- wb_we_i  in  NPORTS  per-port write enable
- wb_stb_i  in  NPORTS  per-port strobe
- wb_cyc_i  in  NPORTS  per-port cycle valid
- wb_ack_o  out  NPORTS  per-port acknowledge
- wb_err_o  out  NPORTS  per-port error
- mem_we  out  1  RAM write strobe
- mem_be  out  DWIDTH/8  RAM byte write enables
- mem_wadr  out  AWIDTH  RAM write address
- mem_radr  out  AWIDTH  RAM read address
- mem_d  out  DWIDTH  RAM write data
- mem_q  in  DWIDTH  RAM read data; valid one cycle after mem_radr is sampled

Behaviour:
- Request: req[p] = wb_cyc_i[p] & wb_stb_i[p].
- States: IDLE, ACC, ACK (registered).
- IDLE:
  - If any req is set, register the grant index gnt and go to ACC.
  - Otherwise stay in IDLE.
- Arbitration, PRIO0=0: the winner is the first requesting port after last_gnt, scanning modulo NPORTS.
- Arbitration, PRIO0=1: port 0 wins whenever req[0] is set; otherwise round-robin over ports 1..NPORTS-1 using the same pointer.
- last_gnt is updated only when a grant is issued. Reset value is NPORTS-1, so port 0 wins the first contested grant.
- ACC, granted port's req still set, sel nonzero:
  - Drive mem_radr and mem_wadr from the granted port's address.
  - Drive mem_d and mem_be from the granted port's data and selects.
  - mem_we = we of the granted port.
  - Go to ACK.
- ACC, sel all zero:
  - No memory access; mem_we stays 0.
  - Set the error flag and go to ACK.
- ACC, req of the granted port has dropped: mem_we = 0; go to IDLE with no ack and no err.
- ACK:
  - wb_ack_o[gnt] = (not error) & req[gnt].
  - wb_err_o[gnt] = error & req[gnt].
  - Exactly one cycle; then go to IDLE.
- Read data: during ACK, wb_dat_o of the granted port = mem_q. Every other port slice is 0. All slices are 0 outside ACK.
- Latency: request sampled in IDLE at cycle N → ack/err in cycle N+2.
- Throughput: at most one access every 3 cycles. A master that keeps stb high after its ack is treated as a new request in the following IDLE.
- Write-then-read of the same address issued in consecutive accesses must return the new data. The RAM must be write-first or the accesses must be separated, which the 3-cycle spacing guarantees.
- Outside ACC: mem_we=0, mem_be=0. mem_radr, mem_wadr and mem_d hold their last value.
- Reset (asynchronous, any state):
  - state=IDLE, gnt=0, last_gnt=NPORTS-1, error=0.
  - All ack/err/dat_o outputs 0; mem_we=0.
  - An access interrupted by reset is dropped with no ack.
- Simultaneous requests from all ports (PRIO0=0): grants rotate 0,1,..,NPORTS-1,0 with no starvation.

Decomposition:
- Shared package vga_clut_pkg:
  - state encoding constants (IDLE/ACC/ACK);
  - function clog2 for index widths;
  - SELW = DWIDTH/8 helper.
- Sub-module vga_rr_arb, parameters NPORTS and PRIO0:
  - inputs: req vector and last_gnt;
  - outputs: gnt index and valid (combinational).
- The top level holds the FSM, the registers and the memory muxing.

Test Plan:
- Single read, NPORTS=2: preload RAM[0x05]=0x123456; port1 reads 0x05 → ack on port1 at N+2, wb_dat_o slice1=0x123456, port0 slice=0.
- Byte write: port0 writes 0xAABBCC to 0x10 with sel=3'b010 over existing 0x000000 → mem_be=010; readback returns 0x00BB00.
- Round-robin, NPORTS=4, PRIO0=0: all ports request continuously → acks in order 0,1,2,3,0,1 at cycles 2,5,8,11,...
- Priority, PRIO0=1, NPORTS=3: ports 0 and 2 request continuously → every grant goes to port 0; dropping port 0 → port 2 is served on the next IDLE.
- Error: sel=0 on port1 → wb_err_o[1]=1 for one cycle; no ack; mem_we never asserted.
- Abort and reset: port0 drops cyc during ACC → no ack, mem_we=0. Asserting wb_rst_i mid-ACK → ack clears immediately, FSM returns to IDLE, and the next contested grant goes to port 0.

Source files
------------

// File: rtl/vga_clut_pkg.sv
// ---------------------------------------------------------------------------
// vga_clut_pkg
// Shared definitions for the multi-port CLUT controller:
//   - state_e : controller FSM encoding (IDLE / ACC / ACK)
//   - clog2   : index width helper, never returns less than 1
//   - selw    : number of byte lanes in a CLUT entry
// ---------------------------------------------------------------------------
package vga_clut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int selw(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/vga_clut_mport_if.sv
// ---------------------------------------------------------------------------
// vga_clut_mport_if
// Bundled Wishbone signals for NPORTS slave ports, packed port-major
// (port p occupies slice [p*W +: W] of each vector). Names are given from
// the controller's point of view.
//   slave  modport : used by the controller
//   master modport : used by whatever drives the ports (VGA fetch, host)
// ---------------------------------------------------------------------------
interface vga_clut_mport_if #(
    parameter int NPORTS = 2,
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 9
);
    localparam int SELW = DWIDTH / 8;

    logic [NPORTS*AWIDTH-1:0] wb_adr_i;
    logic [NPORTS*DWIDTH-1:0] wb_dat_i;
    logic [NPORTS*DWIDTH-1:0] wb_dat_o;
    logic [NPORTS*SELW-1:0]   wb_sel_i;
    logic [NPORTS-1:0]        wb_we_i;
    logic [NPORTS-1:0]        wb_stb_i;
    logic [NPORTS-1:0]        wb_cyc_i;
    logic [NPORTS-1:0]        wb_ack_o;
    logic [NPORTS-1:0]        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/vga_rr_arb.sv
// ---------------------------------------------------------------------------
// vga_rr_arb
// Combinational grant selection for the CLUT controller.
//   req_i      : per-port request vector
//   last_gnt_i : index of the most recently granted port
//   gnt_o      : winning port index
//   valid_o    : at least one port requests
// PRIO0=0 : first requester after last_gnt_i, modulo NPORTS.
// PRIO0=1 : port 0 always wins when requesting; otherwise ports 1..NPORTS-1
//           are scanned round-robin from the same pointer.
// ---------------------------------------------------------------------------
module vga_rr_arb
    import vga_clut_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int PRIO0  = 0,
    parameter int IW     = clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IW-1:0]     last_gnt_i,
    output logic [IW-1:0]     gnt_o,
    output logic              valid_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        // Scan from the farthest candidate down to the nearest so the nearest
        // requester after the pointer is the last (winning) assignment.
        for (int i = NPORTS; i >= 1; i--) begin
            int idx;
            idx = (int'(last_gnt_i) + i) % NPORTS;
            if (req_i[idx] && !(PRIO0 != 0 && idx == 0)) begin
                gnt_o   = IW'(idx);
                valid_o = 1'b1;
            end
        end
        if (PRIO0 != 0 && req_i[0]) begin
            gnt_o   = '0;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/vga_clut_mport.sv
// ---------------------------------------------------------------------------
// vga_clut_mport
// Shares one synchronous-read, byte-writable dual-port CLUT RAM between
// NPORTS Wishbone slave ports. Each access takes IDLE -> ACC -> ACK.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   wb                 : Wishbone slave ports (vga_clut_mport_if.slave)
//   mem_we, mem_be     : RAM write strobe and byte enables (ACC only)
//   mem_wadr, mem_radr : RAM write/read address (held outside ACC)
//   mem_d              : RAM write data (held outside ACC)
//   mem_q              : RAM read data, valid the cycle after mem_radr
// ---------------------------------------------------------------------------
module vga_clut_mport
    import vga_clut_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 9,
    parameter int PRIO0  = 0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    vga_clut_mport_if.slave     wb,
    output logic                mem_we,
    output logic [DWIDTH/8-1:0] mem_be,
    output logic [AWIDTH-1:0]   mem_wadr,
    output logic [AWIDTH-1:0]   mem_radr,
    output logic [DWIDTH-1:0]   mem_d,
    input  logic [DWIDTH-1:0]   mem_q
);
    localparam int SELW = selw(DWIDTH);
    localparam int IW   = clog2(NPORTS);

    state_e              state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]       last_gnt_q, last_gnt_d;
    logic                err_q, err_d;
    logic [AWIDTH-1:0]   radr_q, radr_d;
    logic [AWIDTH-1:0]   wadr_q, wadr_d;
    logic [DWIDTH-1:0]   wdat_q, wdat_d;

    logic [NPORTS-1:0]        req;
    logic [IW-1:0]            arb_gnt;
    logic                     arb_valid;
    logic [NPORTS-1:0]        ack_c, err_c;
    logic [NPORTS*DWIDTH-1:0] dat_c;

    logic                req_g, we_g;
    logic [AWIDTH-1:0]   adr_g;
    logic [DWIDTH-1:0]   dat_g;
    logic [SELW-1:0]     sel_g;

    assign req   = wb.wb_cyc_i & wb.wb_stb_i;
    assign req_g = req[gnt_q];
    assign we_g  = wb.wb_we_i[gnt_q];
    assign adr_g = wb.wb_adr_i[int'(gnt_q)*AWIDTH +: AWIDTH];
    assign dat_g = wb.wb_dat_i[int'(gnt_q)*DWIDTH +: DWIDTH];
    assign sel_g = wb.wb_sel_i[int'(gnt_q)*SELW +: SELW];

    vga_rr_arb #(.NPORTS(NPORTS), .PRIO0(PRIO0), .IW(IW)) u_arb (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (arb_gnt),
        .valid_o    (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        radr_d     = radr_q;
        wadr_d     = wadr_q;
        wdat_d     = wdat_q;
        mem_we     = 1'b0;
        mem_be     = '0;
        ack_c      = '0;
        err_c      = '0;
        dat_c      = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d      = arb_gnt;
                    last_gnt_d = arb_gnt;
                    err_d      = 1'b0;
                    state_d    = ST_ACC;
                end
            end
            ST_ACC: begin
                if (!req_g) begin
                    state_d = ST_IDLE;             // aborted: no ack, no err
                end else if (sel_g == '0) begin
                    err_d   = 1'b1;                // no lanes: terminate with err
                    state_d = ST_ACK;
                end else begin
                    // Address/data flow straight through now and are held
                    // in the _q copies afterwards.
                    radr_d  = adr_g;
                    wadr_d  = adr_g;
                    wdat_d  = dat_g;
                    mem_we  = we_g;
                    mem_be  = sel_g;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_c[gnt_q] = !err_q && req_g;
                err_c[gnt_q] = err_q && req_g;
                dat_c[int'(gnt_q)*DWIDTH +: DWIDTH] = mem_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_radr    = radr_d;
    assign mem_wadr    = wadr_d;
    assign mem_d       = wdat_d;
    assign wb.wb_ack_o = ack_c;
    assign wb.wb_err_o = err_c;
    assign wb.wb_dat_o = dat_c;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IW'(NPORTS - 1);   // port 0 wins the first grant
            err_q      <= 1'b0;
            radr_q     <= '0;
            wadr_q     <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            radr_q     <= radr_d;
            wadr_q     <= wadr_d;
            wdat_q     <= wdat_d;
        end
    end

endmodule

// File: tb/tb_vga_clut_mport.sv
// ---------------------------------------------------------------------------
// tb_vga_clut_mport
// Directed bench for vga_clut_mport. Three instances share one clock:
//   dut_a : NPORTS=2, PRIO0=0 with a byte-writable RAM model
//   dut_b : NPORTS=4, PRIO0=0 (rotation order)
//   dut_c : NPORTS=3, PRIO0=1 (port-0 priority)
// ---------------------------------------------------------------------------
module tb_vga_clut_mport;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A : 2 ports, RAM attached ----------------
    vga_clut_mport_if #(.NPORTS(2), .DWIDTH(24), .AWIDTH(9)) ifa ();
    logic        a_we;
    logic [2:0]  a_be;
    logic [8:0]  a_wadr, a_radr;
    logic [23:0] a_d, a_q;

    vga_clut_mport #(.NPORTS(2), .DWIDTH(24), .AWIDTH(9), .PRIO0(0)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst_a),
        .wb       (ifa.slave),
        .mem_we   (a_we),
        .mem_be   (a_be),
        .mem_wadr (a_wadr),
        .mem_radr (a_radr),
        .mem_d    (a_d),
        .mem_q    (a_q)
    );

    logic [23:0] ram [0:511];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_adr = '0;
    logic [23:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_adr] <= pre_dat;
        else if (a_we) begin
            for (int b = 0; b < 3; b++)
                if (a_be[b]) ram[a_wadr][b*8 +: 8] <= a_d[b*8 +: 8];
        end
        a_q <= ram[a_radr];
    end

    // ---------------- instance B : 4 ports, round-robin ----------------
    vga_clut_mport_if #(.NPORTS(4), .DWIDTH(24), .AWIDTH(9)) ifb ();
    logic        b_we;
    logic [2:0]  b_be;
    logic [8:0]  b_wadr, b_radr;
    logic [23:0] b_d;

    vga_clut_mport #(.NPORTS(4), .DWIDTH(24), .AWIDTH(9), .PRIO0(0)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst_b),
        .wb       (ifb.slave),
        .mem_we   (b_we),
        .mem_be   (b_be),
        .mem_wadr (b_wadr),
        .mem_radr (b_radr),
        .mem_d    (b_d),
        .mem_q    (24'h0)
    );

    // ---------------- instance C : 3 ports, port-0 priority ----------------
    vga_clut_mport_if #(.NPORTS(3), .DWIDTH(24), .AWIDTH(9)) ifc ();
    logic        c_we;
    logic [2:0]  c_be;
    logic [8:0]  c_wadr, c_radr;
    logic [23:0] c_d;

    vga_clut_mport #(.NPORTS(3), .DWIDTH(24), .AWIDTH(9), .PRIO0(1)) dut_c (
        .wb_clk_i (clk),
        .wb_rst_i (rst_c),
        .wb       (ifc.slave),
        .mem_we   (c_we),
        .mem_be   (c_be),
        .mem_wadr (c_wadr),
        .mem_radr (c_radr),
        .mem_d    (c_d),
        .mem_q    (24'h0)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_port(input int p, input logic cyc, input logic we,
                          input logic [8:0] adr, input logic [23:0] dat,
                          input logic [2:0] sel);
        ifa.wb_cyc_i[p]         = cyc;
        ifa.wb_stb_i[p]         = cyc;
        ifa.wb_we_i[p]          = we;
        ifa.wb_adr_i[p*9 +: 9]  = adr;
        ifa.wb_dat_i[p*24 +: 24] = dat;
        ifa.wb_sel_i[p*3 +: 3]  = sel;
    endtask

    task automatic preload(input logic [8:0] adr, input logic [23:0] dat);
        pre_we  = 1'b1;
        pre_adr = adr;
        pre_dat = dat;
        tick();
        pre_we  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] exp_b;
        logic [2:0] exp_c;

        ifa.wb_adr_i = '0; ifa.wb_dat_i = '0; ifa.wb_sel_i = '0;
        ifa.wb_we_i  = '0; ifa.wb_stb_i = '0; ifa.wb_cyc_i = '0;
        ifb.wb_adr_i = '0; ifb.wb_dat_i = '0; ifb.wb_sel_i = '1;
        ifb.wb_we_i  = '0; ifb.wb_stb_i = '0; ifb.wb_cyc_i = '0;
        ifc.wb_adr_i = '0; ifc.wb_dat_i = '0; ifc.wb_sel_i = '1;
        ifc.wb_we_i  = '0; ifc.wb_stb_i = '0; ifc.wb_cyc_i = '0;

        tick(); tick();
        check("rst_ack", 64'(ifa.wb_ack_o), 64'h0);
        check("rst_err", 64'(ifa.wb_err_o), 64'h0);
        check("rst_dat", 64'(ifa.wb_dat_o), 64'h0);
        check("rst_we",  64'(a_we),         64'h0);
        rst_a = 1'b0;

        preload(9'h005, 24'h123456);
        preload(9'h010, 24'h000000);

        // Single read on port 1.
        a_port(1, 1'b1, 1'b0, 9'h005, 24'h0, 3'b111);
        check("rd_ack_c0", 64'(ifa.wb_ack_o), 64'h0);
        tick();
        check("rd_radr",   64'(a_radr), 64'h005);
        check("rd_we",     64'(a_we),   64'h0);
        check("rd_ack_c1", 64'(ifa.wb_ack_o), 64'h0);
        tick();
        check("rd_ack_c2", 64'(ifa.wb_ack_o), 64'h2);
        check("rd_dat1",   64'(ifa.wb_dat_o[47:24]), 64'h123456);
        check("rd_dat0",   64'(ifa.wb_dat_o[23:0]),  64'h0);
        a_port(1, 1'b0, 1'b0, 9'h005, 24'h0, 3'b111);
        tick();
        check("rd_ack_end", 64'(ifa.wb_ack_o), 64'h0);
        check("rd_dat_end", 64'(ifa.wb_dat_o), 64'h0);

        // Byte-lane write on port 0, then read back.
        a_port(0, 1'b1, 1'b1, 9'h010, 24'hAABBCC, 3'b010);
        tick();
        check("bw_we",   64'(a_we),   64'h1);
        check("bw_be",   64'(a_be),   64'h2);
        check("bw_wadr", 64'(a_wadr), 64'h010);
        check("bw_d",    64'(a_d),    64'hAABBCC);
        tick();
        check("bw_ack",  64'(ifa.wb_ack_o), 64'h1);
        check("bw_we_ack", 64'(a_we), 64'h0);
        a_port(0, 1'b0, 1'b0, 9'h010, 24'h0, 3'b000);
        tick();
        check("bw_be_idle",  64'(a_be),   64'h0);
        check("bw_wadr_hold", 64'(a_wadr), 64'h010);
        a_port(0, 1'b1, 1'b0, 9'h010, 24'h0, 3'b111);
        tick();
        tick();
        check("bw_rb_ack", 64'(ifa.wb_ack_o), 64'h1);
        check("bw_rb_dat", 64'(ifa.wb_dat_o[23:0]), 64'h00BB00);
        a_port(0, 1'b0, 1'b0, 9'h010, 24'h0, 3'b000);
        tick();

        // Zero byte-select on port 1 terminates with err.
        a_port(1, 1'b1, 1'b1, 9'h020, 24'h777777, 3'b000);
        tick();
        check("er_we_acc", 64'(a_we), 64'h0);
        tick();
        check("er_err", 64'(ifa.wb_err_o), 64'h2);
        check("er_ack", 64'(ifa.wb_ack_o), 64'h0);
        check("er_we_ack", 64'(a_we), 64'h0);
        a_port(1, 1'b0, 1'b0, 9'h020, 24'h0, 3'b000);
        tick();
        check("er_err_end", 64'(ifa.wb_err_o), 64'h0);

        // Abort: port 0 drops cyc while in ACC.
        a_port(0, 1'b1, 1'b1, 9'h030, 24'h111111, 3'b111);
        tick();
        a_port(0, 1'b0, 1'b1, 9'h030, 24'h111111, 3'b111);
        #1;
        check("ab_we", 64'(a_we), 64'h0);
        tick();
        check("ab_ack1", 64'(ifa.wb_ack_o), 64'h0);
        tick();
        check("ab_ack2", 64'(ifa.wb_ack_o), 64'h0);

        // Reset in the middle of ACK, then the next contested grant.
        a_port(1, 1'b1, 1'b0, 9'h005, 24'h0, 3'b111);
        tick();
        tick();
        check("rs_ack_pre", 64'(ifa.wb_ack_o), 64'h2);
        a_port(0, 1'b1, 1'b0, 9'h010, 24'h0, 3'b111);
        rst_a = 1'b1;
        #1;
        check("rs_ack_clr", 64'(ifa.wb_ack_o), 64'h0);
        check("rs_dat_clr", 64'(ifa.wb_dat_o), 64'h0);
        tick();
        rst_a = 1'b0;
        tick();
        check("rs_acc_ack", 64'(ifa.wb_ack_o), 64'h0);
        tick();
        check("rs_gnt0", 64'(ifa.wb_ack_o), 64'h1);
        a_port(0, 1'b0, 1'b0, 9'h0, 24'h0, 3'b000);
        a_port(1, 1'b0, 1'b0, 9'h0, 24'h0, 3'b000);

        // Round-robin, 4 ports all requesting.
        rst_b = 1'b0;
        ifb.wb_cyc_i = 4'hF;
        ifb.wb_stb_i = 4'hF;
        for (int k = 0; k < 18; k++) begin
            exp_b = (k % 3 == 2) ? 4'(1 << ((k / 3) % 4)) : 4'h0;
            check($sformatf("rr_ack_k%0d", k), 64'(ifb.wb_ack_o), 64'(exp_b));
            tick();
        end
        ifb.wb_cyc_i = 4'h0;
        ifb.wb_stb_i = 4'h0;

        // Port-0 priority with ports 0 and 2 requesting.
        rst_c = 1'b0;
        ifc.wb_cyc_i = 3'b101;
        ifc.wb_stb_i = 3'b101;
        for (int k = 0; k < 12; k++) begin
            if (k < 9)       exp_c = (k % 3 == 2) ? 3'b001 : 3'b000;
            else if (k == 11) exp_c = 3'b100;
            else             exp_c = 3'b000;
            check($sformatf("pr_ack_k%0d", k), 64'(ifc.wb_ack_o), 64'(exp_c));
            if (k == 9) begin
                ifc.wb_cyc_i = 3'b100;
                ifc.wb_stb_i = 3'b100;
            end
            tick();
        end
        ifc.wb_cyc_i = 3'b000;
        ifc.wb_stb_i = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
